// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the request legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_DATA = 2'd2,
    WR      = 2'd3
  } lsu_state_t;

  // Unknown width code for the direction, or a halfword/word not naturally aligned.
  function automatic logic req_malformed(input logic we, input logic [2:0] f3,
                                         input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr_lo[0];
      F3_W:    bad = (addr_lo != 2'b00);
      F3_BU:   bad = we;
      F3_HU:   bad = we | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Lane steering for sub-word accesses: extract/extend a load lane and merge a
// store lane into a previously read word.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = word_i[{addr_lo_i[1], 4'b0000} +: 16];

    load_data_o = word_i;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data_o = {24'd0, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data_o = {16'd0, half_sel};
      default: load_data_o = word_i;
    endcase

    // Bytes outside the selected lane keep their freshly read value.
    merge_data_o = word_i;
    case (funct3_i)
      F3_B:    merge_data_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_H:    merge_data_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i;
      default: merge_data_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: checks a byte-addressed request, then issues word reads,
// writes or read-modify-write sequences and returns a one-cycle response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  // Request handshake: a transfer happens on a rising edge where req_valid and
  // req_ready are both high; req_ready is high exactly while the FSM is IDLE.
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  input  logic [31:0] mem_read_data,
  output logic [1:0]  dbg_state
);

  lsu_state_t  state_q, state_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic [15:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_write_data_q, mem_write_data_d;

  logic [31:0] lane_load;
  logic [31:0] lane_merge;
  logic        req_bad;

  lsu_byte_lane u_lane (
    .funct3_i     (f3_q),
    .addr_lo_i    (addr_lo_q),
    .word_i       (mem_read_data),
    .wdata_i      (wdata_q),
    .load_data_o  (lane_load),
    .merge_data_o (lane_merge)
  );

  assign req_bad = req_malformed(req_we, req_funct3, req_addr[1:0]) ||
                   ({2'b00, req_addr[31:2]} >= 32'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    addr_lo_d        = addr_lo_q;
    f3_d             = f3_q;
    we_d             = we_q;
    wdata_d          = wdata_q;
    resp_valid_d     = 1'b0;
    resp_err_d       = 1'b0;
    resp_rdata_d     = 32'd0;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_lo_d = req_addr[1:0];
          f3_d      = req_funct3;
          we_d      = req_we;
          wdata_d   = req_wdata[15:0];
          if (req_bad) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            mem_address_d = {2'b00, req_addr[31:2]};
            if (req_we && (req_funct3 == F3_W)) begin
              mem_write_data_d = req_wdata;
              state_d          = WR;
            end else begin
              state_d = RD_REQ;
            end
          end
        end
      end
      RD_REQ: state_d = RD_DATA;
      RD_DATA: begin
        if (we_q) begin
          mem_write_data_d = lane_merge;
          state_d          = WR;
        end else begin
          resp_valid_d = 1'b1;
          resp_rdata_d = lane_load;
          state_d      = IDLE;
        end
      end
      WR: begin
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_lo_q        <= 2'd0;
      f3_q             <= 3'd0;
      we_q             <= 1'b0;
      wdata_q          <= 16'd0;
      resp_valid_q     <= 1'b0;
      resp_err_q       <= 1'b0;
      resp_rdata_q     <= 32'd0;
      mem_address_q    <= 32'd0;
      mem_write_data_q <= 32'd0;
    end else begin
      addr_lo_q        <= addr_lo_d;
      f3_q             <= f3_d;
      we_q             <= we_d;
      wdata_q          <= wdata_d;
      resp_valid_q     <= resp_valid_d;
      resp_err_q       <= resp_err_d;
      resp_rdata_q     <= resp_rdata_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
    end
  end

  // Strobes decode directly from the registered state, so they are glitch-free
  // and can never be high together.
  assign req_ready        = (state_q == IDLE);
  assign mem_read_enable  = (state_q == RD_REQ);
  assign mem_write_enable = (state_q == WR);
  assign resp_valid       = resp_valid_q;
  assign resp_err         = resp_err_q;
  assign resp_rdata       = resp_rdata_q;
  assign mem_address      = mem_address_q;
  assign mem_write_data   = mem_write_data_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a one-cycle-latency word memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [31:0] mem_read_data;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] mem [0:255];
  logic        pl_we = 1'b0;
  logic [7:0]  pl_idx = 8'd0;
  logic [31:0] pl_data = 32'd0;
  logic [31:0] exp_q[$];

  load_store_unit #(.DEPTH(256)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_err         (resp_err),
    .resp_rdata       (resp_rdata),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_read_data    (mem_read_data),
    .dbg_state        (dbg_state)
  );

  // Clock and memory model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_we) mem[pl_idx] <= pl_data;
    if (mem_read_enable) mem_read_data <= mem[mem_address[7:0]];
    if (mem_write_enable) mem[mem_address[7:0]] <= mem_write_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_we   = 1'b1;
    pl_idx  = idx;
    pl_data = data;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Issue one request and observe 8 cycles; offsets count cycles after transfer.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata,
                        input int exp_rd_off, input int exp_wr_off,
                        input logic [31:0] exp_idx, input logic [31:0] exp_wdata);
    int lat = 0, resp_n = 0, rd_n = 0, wr_n = 0, rd_off = 0, wr_off = 0, both = 0;
    logic [31:0] rd_idx = 0, wr_idx = 0, wr_data = 0, rdata = 0;
    logic err = 1'b0;
    @(negedge clk);
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (mem_read_enable && mem_write_enable) both++;
      if (mem_read_enable) begin rd_n++; rd_off = k; rd_idx = mem_address; end
      if (mem_write_enable) begin wr_n++; wr_off = k; wr_idx = mem_address; wr_data = mem_write_data; end
      if (resp_valid) begin
        resp_n++;
        if (lat == 0) begin lat = k; err = resp_err; rdata = resp_rdata; end
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " resp count"}, 32'(resp_n), 32'd1);
    chk({tag, " resp_err"}, 32'(err), 32'(exp_err));
    chk({tag, " resp_rdata"}, rdata, exp_rdata);
    chk({tag, " read strobes"}, 32'(rd_n), (exp_rd_off != 0) ? 32'd1 : 32'd0);
    chk({tag, " write strobes"}, 32'(wr_n), (exp_wr_off != 0) ? 32'd1 : 32'd0);
    chk({tag, " strobe overlap"}, 32'(both), 32'd0);
    if (exp_rd_off != 0) begin
      chk({tag, " read offset"}, 32'(rd_off), 32'(exp_rd_off));
      chk({tag, " read index"}, rd_idx, exp_idx);
    end
    if (exp_wr_off != 0) begin
      chk({tag, " write offset"}, 32'(wr_off), 32'(exp_wr_off));
      chk({tag, " write index"}, wr_idx, exp_idx);
      chk({tag, " write data"}, wr_data, exp_wdata);
    end
  endtask

  initial begin
    int wr_seen, resp_seen;
    logic [31:0] got;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;

    // Reset state and memory preload
    preload(8'd4,   32'h8899AABB);
    preload(8'd2,   32'h11223344);
    preload(8'd8,   32'h00000000);
    preload(8'd255, 32'h0BADF00D);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset mem_read_enable", 32'(mem_read_enable), 32'd0);
    chk("reset mem_write_enable", 32'(mem_write_enable), 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    chk("reset mem_address", mem_address, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset req_ready", 32'(req_ready), 32'd1);

    // Loads from word 4 = 0x8899AABB
    do_req("LB 0x12",  1'b0, F3_B,  32'h12, 32'h0, 3, 1'b0, 32'hFFFFFF99, 1, 0, 32'd4, 32'h0);
    do_req("LBU 0x12", 1'b0, F3_BU, 32'h12, 32'h0, 3, 1'b0, 32'h00000099, 1, 0, 32'd4, 32'h0);
    do_req("LHU 0x12", 1'b0, F3_HU, 32'h12, 32'h0, 3, 1'b0, 32'h00008899, 1, 0, 32'd4, 32'h0);

    // Sub-word stores as read-modify-write
    do_req("SB 0x11",  1'b1, F3_B,  32'h11, 32'h123456CC, 4, 1'b0, 32'h0, 1, 3, 32'd4, 32'h8899CCBB);
    do_req("LW 0x10",  1'b0, F3_W,  32'h10, 32'h0, 3, 1'b0, 32'h8899CCBB, 1, 0, 32'd4, 32'h0);
    do_req("LH 0x10",  1'b0, F3_H,  32'h10, 32'h0, 3, 1'b0, 32'hFFFFCCBB, 1, 0, 32'd4, 32'h0);
    do_req("SH 0x12",  1'b1, F3_H,  32'h12, 32'hABCD1234, 4, 1'b0, 32'h0, 1, 3, 32'd4, 32'h1234CCBB);
    do_req("LB 0x13",  1'b0, F3_B,  32'h13, 32'h0, 3, 1'b0, 32'h00000012, 1, 0, 32'd4, 32'h0);

    // Full-word store and top-of-memory load
    do_req("SW 0x20",  1'b1, F3_W,  32'h20, 32'hDEADBEEF, 2, 1'b0, 32'h0, 0, 1, 32'd8, 32'hDEADBEEF);
    do_req("LW 0x20",  1'b0, F3_W,  32'h20, 32'h0, 3, 1'b0, 32'hDEADBEEF, 1, 0, 32'd8, 32'h0);
    do_req("LW 0x3FC", 1'b0, F3_W,  32'h3FC, 32'h0, 3, 1'b0, 32'h0BADF00D, 1, 0, 32'd255, 32'h0);

    // Rejected requests: misalignment, range, illegal width codes
    do_req("err LH 0x11",  1'b0, F3_H, 32'h11,  32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0, 32'h0);
    do_req("err SW 0x402", 1'b1, F3_W, 32'h402, 32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0, 32'h0);
    do_req("err SW 0x400", 1'b1, F3_W, 32'h400, 32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0, 32'h0);
    do_req("err LD f3=3",  1'b0, 3'd3, 32'h0,   32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0, 32'h0);
    do_req("err ST f3=4",  1'b1, 3'd4, 32'h0,   32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0, 32'h0);
    do_req("err LW 0x02",  1'b0, F3_W, 32'h2,   32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0, 32'h0);

    // Reset during RD_DATA of an SH
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_H;
    req_addr   = 32'h08;
    req_wdata  = 32'h00005555;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst-mid state", 32'(dbg_state), 32'(RD_DATA));
    rst = 1'b1;
    #1;
    chk("rst-mid state idle", 32'(dbg_state), 32'(IDLE));
    chk("rst-mid resp_valid", 32'(resp_valid), 32'd0);
    chk("rst-mid resp_err", 32'(resp_err), 32'd0);
    chk("rst-mid read_enable", 32'(mem_read_enable), 32'd0);
    chk("rst-mid write_enable", 32'(mem_write_enable), 32'd0);
    chk("rst-mid resp_rdata", resp_rdata, 32'd0);
    chk("rst-mid mem_address", mem_address, 32'd0);
    chk("rst-mid mem_write_data", mem_write_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wr_seen = 0;
    resp_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mem_write_enable) wr_seen++;
      if (resp_valid) resp_seen++;
    end
    chk("rst-mid write strobes", 32'(wr_seen), 32'd0);
    chk("rst-mid responses", 32'(resp_seen), 32'd0);
    chk("rst-mid req_ready", 32'(req_ready), 32'd1);
    chk("rst-mid word 2 intact", mem[2], 32'h11223344);

    // Back-to-back loads: second issued in the cycle of the first response
    exp_q.push_back(32'h1234CCBB);
    exp_q.push_back(32'hDEADBEEF);
    resp_seen = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = F3_W;
    req_addr   = 32'h10;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1 || k == 4) req_valid = 1'b0;
      if (resp_valid) begin
        resp_seen++;
        chk("b2b resp offset", 32'(k), (resp_seen == 1) ? 32'd3 : 32'd6);
        got = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
        chk("b2b resp_rdata", resp_rdata, got);
      end
      if (k == 3) begin
        chk("b2b ready at response", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = 32'h20;
      end
    end
    chk("b2b response count", 32'(resp_seen), 32'd2);
    chk("b2b queue drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
